// File: rtl/fp_add_normalize.sv
// rtl/fp_add_normalize.sv - FP adder back end: mantissa add, sign fix-up, left normalize, pack
// Optional FAST_NORM_EN: single-cycle leading-zero normalizer instead of one shift per cycle.
module fp_add_normalize #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      s1,
  input  logic [EXP_W-1:0]          e_in,
  input  logic [MANT_W-1:0]         op1,
  input  logic [MANT_W-1:0]         op2,
  input  logic                      flag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   result,
  output logic                      busy
);

  localparam int RES_W = EXP_W + MANT_W;

  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

  state_t              state_q, state_d;
  logic                s1_q, s1_d, flag_q, flag_d, sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   op1_q, op1_d, op2_q, op2_d, mant_q, mant_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;

  logic [MANT_W:0]     sum;
  logic [EXP_W:0]      exp_inc;
  logic [MANT_W-1:0]   add_mant;
  logic [EXP_W-1:0]    add_exp;
  logic                add_sign, add_inf;

  logic [MANT_W-1:0]   norm_mant;
  logic [EXP_W-1:0]    norm_exp;
  logic                norm_flush, norm_done;

  // op2 arrives already negated for subtraction, so a carry out means op1 >= |op2|
  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    exp_inc  = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
    add_mant = sum[MANT_W-1:0];
    add_exp  = exp_q;
    add_sign = s1_q;
    add_inf  = 1'b0;
    if (!flag_q) begin
      if (sum[MANT_W]) begin
        add_mant = sum[MANT_W:1];
        add_exp  = exp_inc[EXP_W-1:0];
        add_inf  = (exp_inc >= {1'b0, {EXP_W{1'b1}}});
      end
    end else if (op2_q == '0) begin
      add_mant = op1_q;
    end else if (!sum[MANT_W]) begin
      add_mant = ~sum[MANT_W-1:0] + {{(MANT_W-1){1'b0}}, 1'b1};
      add_sign = ~s1_q;
    end
  end

`ifdef FAST_NORM_EN
  localparam int LZ_W = $clog2(MANT_W + 1);
  logic [LZ_W-1:0]  lz;
  logic [EXP_W-1:0] lz_ext;

  always_comb begin
    lz = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (mant_q[i]) lz = LZ_W'(MANT_W - 1 - i);
    end
  end

  assign lz_ext = EXP_W'(lz);

  always_comb begin
    norm_mant  = mant_q << lz;
    norm_exp   = exp_q - lz_ext;
    norm_flush = (exp_q <= lz_ext);
    norm_done  = 1'b1;
  end
`else
  // Shift and leading-bit test share a cycle so k shifts cost exactly k cycles
  always_comb begin
    norm_mant  = {mant_q[MANT_W-2:0], 1'b0};
    norm_exp   = exp_q - EXP_W'(1);
    norm_flush = (exp_q <= EXP_W'(1));
    norm_done  = norm_mant[MANT_W-1];
  end
`endif

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    flag_d      = flag_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    mant_d      = mant_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s1_d       = s1;
          exp_d      = e_in;
          op1_d      = op1;
          op2_d      = op2;
          flag_d     = flag;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ADD;
        end
      end
      ADD: begin
        mant_d = add_mant;
        exp_d  = add_exp;
        sign_d = add_sign;
        if (add_inf) begin
          result_d    = {s1_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (add_mant == '0) begin
          result_d    = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (add_mant[MANT_W-1]) begin
          result_d    = {add_sign, add_exp, add_mant[MANT_W-2:0]};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (norm_flush) begin
          result_d    = {sign_q, {(RES_W-1){1'b0}}};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          mant_d = norm_mant;
          exp_d  = norm_exp;
          if (norm_done) begin
            result_d    = {sign_q, norm_exp, norm_mant[MANT_W-2:0]};
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      flag_q      <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      mant_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      flag_q      <= flag_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      mant_q      <= mant_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
